// File: rtl/core_mc.sv
// core_mc: multi-cycle 16-bit-instruction core (FETCH/EXEC/WB/HALT), 16 x DATA_W regs.
// Ports: clk, rst (sync, active-high); im_req/im_addr/im_valid/im_data fetch port;
//        wb_en/wb_addr/wb_data write trace; halted, illegal pulse, instret count.
// Optional: define CORE_MC_MUL_EN to add opcode 0xA MUL (otherwise 0xA is illegal).
module core_mc #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              im_req,
    output logic [PC_W-1:0]   im_addr,
    input  logic              im_valid,
    input  logic [15:0]       im_data,
    output logic              wb_en,
    output logic [3:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              halted,
    output logic              illegal,
    output logic [15:0]       instret
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     r_pc_nxt;
    logic [15:0]         r_ir;
    logic [DATA_W-1:0]   r_rf [16];
    logic                r_wb_en;
    logic [3:0]          r_wb_addr;
    logic [DATA_W-1:0]   r_wb_data;
    logic                r_illegal;
    logic                r_halted;
    logic [15:0]         r_instret;

    logic [3:0]          w_op;
    logic [3:0]          w_rd;
    logic [3:0]          w_rs;
    logic [7:0]          w_imm;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [DATA_W-1:0]   w_sext;
    logic [DATA_W-1:0]   w_res;
    logic                w_wr;
    logic                w_ill;
    logic                w_jump;
    logic [PC_W-1:0]     w_pc_inc;
    logic [PC_W-1:0]     w_target;

    assign w_op     = r_ir[15:12];
    assign w_rd     = r_ir[11:8];
    assign w_rs     = r_ir[7:4];
    assign w_imm    = r_ir[7:0];
    assign w_a      = r_rf[w_rd];
    assign w_b      = r_rf[w_rs];
    assign w_sext   = DATA_W'($signed(w_imm));
    assign w_pc_inc = r_pc + 1'b1;
    assign w_target = w_imm[PC_W-1:0];

`ifdef CORE_MC_MUL_EN
    logic [DATA_W-1:0]   w_mul;
    assign w_mul = w_a * w_b;
`endif

    always_comb begin
        w_res  = '0;
        w_wr   = 1'b0;
        w_ill  = 1'b0;
        w_jump = 1'b0;
        case (w_op)
            4'h0: ;
            4'h1: begin w_res = w_sext;    w_wr = 1'b1; end
            4'h2: begin w_res = w_a + w_b; w_wr = 1'b1; end
            4'h3: begin w_res = w_a - w_b; w_wr = 1'b1; end
            4'h4: begin w_res = w_a & w_b; w_wr = 1'b1; end
            4'h5: begin w_res = w_a | w_b; w_wr = 1'b1; end
            4'h6: begin w_res = w_a ^ w_b; w_wr = 1'b1; end
            4'h7: begin w_res = w_b;       w_wr = 1'b1; end
            4'h8: w_jump = (w_a == '0);
            4'h9: w_jump = 1'b1;
`ifdef CORE_MC_MUL_EN
            4'hA: begin w_res = w_mul;     w_wr = 1'b1; end
`endif
            4'hF: ;
            default: w_ill = 1'b1;
        endcase
    end

    // Fetch request drops immediately while rst is high so an aborted
    // fetch is visibly withdrawn and any stale im_valid is ignored.
    assign im_req  = (r_state == S_FETCH) && !rst;
    assign im_addr = r_pc;
    assign wb_en   = r_wb_en;
    assign wb_addr = r_wb_addr;
    assign wb_data = r_wb_data;
    assign halted  = r_halted;
    assign illegal = r_illegal;
    assign instret = r_instret;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_pc_nxt  <= '0;
            r_ir      <= '0;
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_illegal <= 1'b0;
            r_halted  <= 1'b0;
            r_instret <= '0;
            for (int i = 0; i < 16; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (im_valid) begin
                        r_ir    <= im_data;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_op == 4'hF) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        if (r_instret != 16'hFFFF) begin
                            r_instret <= r_instret + 16'd1;
                        end
                    end else begin
                        r_state   <= S_WB;
                        r_wb_en   <= w_wr;
                        r_wb_addr <= w_wr ? w_rd : 4'd0;
                        r_wb_data <= w_wr ? w_res : '0;
                        r_illegal <= w_ill;
                        r_pc_nxt  <= w_jump ? w_target : w_pc_inc;
                    end
                end
                S_WB: begin
                    // The write commits at the end of the WB cycle, so a
                    // reset during WB still cancels it.
                    if (r_wb_en) begin
                        r_rf[r_wb_addr] <= r_wb_data;
                    end
                    r_pc      <= r_pc_nxt;
                    r_wb_en   <= 1'b0;
                    r_wb_addr <= '0;
                    r_wb_data <= '0;
                    r_illegal <= 1'b0;
                    r_state   <= S_FETCH;
                    if (r_instret != 16'hFFFF) begin
                        r_instret <= r_instret + 16'd1;
                    end
                end
                S_HALT: ;
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule
